// File: rtl/axis_pkt_pkg.sv
// Shared FSM state encoding and packet-mode constants for the frame packetizer.
package axis_pkt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/axis_frame_packetizer_if.sv
// Generic valid/ready stream bundle; dat carries the payload (tdata plus any sideband bits).
interface axis_frame_packetizer_if #(
    parameter int W = 33
);
    logic [W-1:0] dat;
    logic         vld;
    logic         rdy;

    modport master (output dat, output vld, input rdy);
    modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output, 1-cycle latency, full throughput.
// in_if.rdy comes straight from a flop, so it never sees out_if.rdy combinationally.
module axis_skid_buffer #(
    parameter int W = 33
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    axis_frame_packetizer_if.slave         in_if,
    axis_frame_packetizer_if.master        out_if
);

    logic [W-1:0] out_dat_q;
    logic [W-1:0] skid_dat_q;
    logic         out_vld_q;
    logic         skid_vld_q;
    logic         in_acc;
    logic         out_free;

    assign in_if.rdy  = ~skid_vld_q;
    assign in_acc     = in_if.vld & ~skid_vld_q;
    assign out_free   = out_if.rdy | ~out_vld_q;
    assign out_if.vld = out_vld_q;
    assign out_if.dat = out_dat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_dat_q  <= '0;
            skid_dat_q <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (out_free) begin
            // The skid entry is older than anything upstream, so it drains first.
            if (skid_vld_q) begin
                out_dat_q  <= skid_dat_q;
                out_vld_q  <= 1'b1;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q <= in_acc;
                if (in_acc) begin
                    out_dat_q <= in_if.dat;
                end
            end
        end else if (in_acc) begin
            skid_dat_q <= in_if.dat;
            skid_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_frame_packetizer.sv
// Cuts an AXI-Stream into fixed-length packets (tlast), continuous or triggered bursts.
// One cycle input-to-output latency via a skid buffer; source is throttled, never dropped.
module axis_frame_packetizer
    import axis_pkt_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic                        cfg_mode,
    input  logic [CNTR_WIDTH-1:0]       cfg_pkts,
    input  logic                        cfg_trig,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        sts_busy,
    output logic [CNTR_WIDTH-1:0]       sts_pkt_cntr
);

    localparam int                    BW      = AXIS_TDATA_WIDTH + 1;
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    state_e                  state_q;
    logic [CNTR_WIDTH-1:0]   len_q;
    logic [CNTR_WIDTH-1:0]   beat_cnt_q;
    logic [CNTR_WIDTH-1:0]   pkt_left_q;
    logic [CNTR_WIDTH-1:0]   pkt_cntr_q;
    logic                    mode_q;

    logic                    run;
    logic                    beat_acc;
    logic                    beat_last;
    logic                    cont_start;
    logic                    burst_start;
    logic                    stay_run;

    axis_frame_packetizer_if #(.W(BW)) up_if ();
    axis_frame_packetizer_if #(.W(BW)) dn_if ();

    assign run           = (state_q == RUN);
    assign s_axis_tready = run & up_if.rdy;
    assign beat_acc      = s_axis_tvalid & s_axis_tready;
    assign beat_last     = (beat_cnt_q == len_q - CNT_ONE);
    assign sts_busy      = run;
    assign sts_pkt_cntr  = pkt_cntr_q;

    assign cont_start  = (cfg_mode == MODE_CONT) && (cfg_length != '0);
    assign burst_start = (cfg_mode == MODE_BURST) && cfg_trig &&
                         (cfg_length != '0) && (cfg_pkts != '0);
    // A zero length is never re-latched into RUN, so len_q - 1 stays meaningful.
    assign stay_run    = cont_start ||
                         ((cfg_mode == MODE_BURST) && (cfg_length != '0) &&
                          (pkt_left_q > CNT_ONE));

    assign up_if.vld = s_axis_tvalid & run;
    assign up_if.dat = {beat_last, s_axis_tdata};

    assign dn_if.rdy     = m_axis_tready;
    assign m_axis_tvalid = dn_if.vld;
    assign m_axis_tdata  = dn_if.dat[AXIS_TDATA_WIDTH-1:0];
    assign m_axis_tlast  = dn_if.dat[AXIS_TDATA_WIDTH];

    axis_skid_buffer #(.W(BW)) u_skid (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .in_if  (up_if),
        .out_if (dn_if)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            pkt_left_q <= '0;
            pkt_cntr_q <= '0;
            mode_q     <= MODE_CONT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cont_start) begin
                        state_q    <= RUN;
                        len_q      <= cfg_length;
                        beat_cnt_q <= '0;
                        mode_q     <= MODE_CONT;
                    end else if (burst_start) begin
                        state_q    <= RUN;
                        len_q      <= cfg_length;
                        beat_cnt_q <= '0;
                        pkt_left_q <= cfg_pkts;
                        mode_q     <= MODE_BURST;
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        if (beat_last) begin
                            beat_cnt_q <= '0;
                            pkt_cntr_q <= pkt_cntr_q + CNT_ONE;
                            if (mode_q == MODE_BURST) begin
                                pkt_left_q <= pkt_left_q - CNT_ONE;
                            end
                            if (stay_run) begin
                                len_q  <= cfg_length;
                                mode_q <= cfg_mode;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_packetizer.sv
// Randomised bench for the frame packetizer: beats are logged at both ports and
// compared against packet boundaries computed from the configured packet lengths.
module tb_axis_frame_packetizer;

    localparam int DW = 32;
    localparam int CW = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          aclk;
    logic          aresetn;
    logic [CW-1:0] cfg_length;
    logic [CW-1:0] cfg_pkts;
    logic          cfg_mode;
    logic          cfg_trig;
    logic          m_last;
    logic          sts_busy;
    logic [CW-1:0] sts_pkt_cntr;

    axis_frame_packetizer_if #(.W(DW)) src_if ();
    axis_frame_packetizer_if #(.W(DW)) snk_if ();

    axis_frame_packetizer #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_length    (cfg_length),
        .cfg_mode      (cfg_mode),
        .cfg_pkts      (cfg_pkts),
        .cfg_trig      (cfg_trig),
        .s_axis_tready (src_if.rdy),
        .s_axis_tdata  (src_if.dat),
        .s_axis_tvalid (src_if.vld),
        .m_axis_tready (snk_if.rdy),
        .m_axis_tdata  (snk_if.dat),
        .m_axis_tvalid (snk_if.vld),
        .m_axis_tlast  (m_last),
        .sts_busy      (sts_busy),
        .sts_pkt_cntr  (sts_pkt_cntr)
    );

    logic [DW-1:0] in_q[$];
    beat_t         out_q[$];
    int            out_cyc[$];
    int            exp_len[$];
    int            checks = 0;
    int            fails = 0;
    int            cyc_cnt = 0;
    int            stall_viol = 0;
    bit            sink_rand = 0;
    bit            sink_on = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // Sink: ready either held by sink_on or randomised 50% each cycle.
    initial begin
        snk_if.rdy = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            snk_if.rdy = sink_rand ? 1'($urandom_range(1)) : sink_on;
        end
    end

    // Output monitor: logs transfers and counts changes of a stalled beat.
    initial begin
        bit            ps;
        logic [DW-1:0] pd;
        logic          pl;
        ps = 0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                ps = 0;
            end else begin
                if (ps && (snk_if.vld !== 1'b1 || snk_if.dat !== pd || m_last !== pl))
                    stall_viol++;
                if (snk_if.vld && snk_if.rdy) begin
                    out_q.push_back({snk_if.dat, m_last});
                    out_cyc.push_back(cyc_cnt);
                end
                ps = snk_if.vld && !snk_if.rdy;
                pd = snk_if.dat;
                pl = m_last;
            end
        end
    end

    // Expected tlast from the list of packet lengths; the final entry repeats.
    function automatic logic is_last(input int i);
        int pos;
        int len;
        pos = i;
        for (int k = 0; k < 100000; k++) begin
            len = exp_len[(k < exp_len.size()) ? k : exp_len.size() - 1];
            if (pos < len) return (pos == len - 1);
            pos -= len;
        end
        return 1'b0;
    endfunction

    task automatic do_reset(input int len, input logic mode, input int pkts);
        aresetn     = 1'b0;
        src_if.vld  = 1'b0;
        src_if.dat  = '0;
        cfg_trig    = 1'b0;
        cfg_length  = CW'(len);
        cfg_mode    = mode;
        cfg_pkts    = CW'(pkts);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        in_q.delete();
        out_q.delete();
        out_cyc.delete();
        stall_viol = 0;
    endtask

    task automatic send(input int n, input int vpct, output int sent, output int cycles);
        logic acc;
        sent   = 0;
        cycles = 0;
        src_if.dat = $urandom;
        src_if.vld = ($urandom_range(99) < vpct);
        while (sent < n && cycles < 2000) begin
            @(negedge aclk);
            acc = src_if.vld && src_if.rdy;
            if (acc) begin
                in_q.push_back(src_if.dat);
                sent++;
            end
            @(posedge aclk);
            #1;
            cycles++;
            if (acc || !src_if.vld) begin
                src_if.dat = $urandom;
                src_if.vld = ($urandom_range(99) < vpct);
            end
        end
        src_if.vld = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        int c;
        c = 0;
        while (out_q.size() < n && c < budget) begin
            @(posedge aclk);
            c++;
        end
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        cfg_length = '0;
        cfg_mode   = 1'b0;
        cfg_pkts   = '0;
        cfg_trig   = 1'b0;
        src_if.vld = 1'b1;
        src_if.dat = 32'hdead_beef;
        aresetn    = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({src_if.rdy, snk_if.vld, m_last, sts_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got tready/tvalid/tlast/busy=%b want 0000",
                     {src_if.rdy, snk_if.vld, m_last, sts_busy});
        end
        checks++;
        if (sts_pkt_cntr !== '0) begin
            fails++;
            $display("FAIL reset_pkt_cntr: got %0d want 0", sts_pkt_cntr);
        end
        src_if.vld = 1'b0;
    endtask

    task automatic test_continuous();
        int sent;
        int cycles;
        do_reset(4, 1'b0, 0);
        sink_rand = 0;
        sink_on   = 1;
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if (sts_busy !== 1'b1) begin
            fails++;
            $display("FAIL cont_busy: got %b want 1", sts_busy);
        end
        exp_len = '{4};
        send(12, 100, sent, cycles);
        drain(12, 100);
        checks++;
        if (cycles !== 12) begin
            fails++;
            $display("FAIL cont_rate: 12 beats took %0d cycles, want 12", cycles);
        end
        checks++;
        if (out_q.size() !== 12) begin
            fails++;
            $display("FAIL cont_count: got %0d beats want 12", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++;
            if (out_q[i].d !== in_q[i] || out_q[i].l !== is_last(i) ||
                out_cyc[i] - out_cyc[0] != i) begin
                fails++;
                $display("FAIL cont_beat%0d: got d=%h l=%b cyc+%0d want d=%h l=%b cyc+%0d",
                         i, out_q[i].d, out_q[i].l, out_cyc[i] - out_cyc[0],
                         in_q[i], is_last(i), i);
            end
        end
        checks++;
        if (sts_pkt_cntr !== 32'd3) begin
            fails++;
            $display("FAIL cont_pkt_cntr: got %0d want 3", sts_pkt_cntr);
        end
    endtask

    task automatic test_burst();
        int sent;
        int cycles;
        int extra;
        do_reset(3, 1'b1, 2);
        sink_on = 1;
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if (sts_busy !== 1'b0) begin
            fails++;
            $display("FAIL burst_wait_trig: busy=%b want 0", sts_busy);
        end
        cfg_trig = 1'b1;
        @(posedge aclk);
        #1;
        cfg_trig = 1'b0;
        exp_len = '{3};
        fork
            send(6, 100, sent, cycles);
            begin
                repeat (2) @(posedge aclk);
                #1;
                cfg_trig = 1'b1;
                @(posedge aclk);
                #1;
                cfg_trig = 1'b0;
            end
        join
        checks++;
        if (src_if.rdy !== 1'b0 || sts_busy !== 1'b0) begin
            fails++;
            $display("FAIL burst_end_idle: tready=%b busy=%b want 0 0", src_if.rdy, sts_busy);
        end
        extra = 0;
        src_if.vld = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            if (src_if.rdy) extra++;
        end
        src_if.vld = 1'b0;
        drain(6, 50);
        checks++;
        if (extra !== 0 || out_q.size() !== 6) begin
            fails++;
            $display("FAIL burst_count: got %0d beats out, %0d extra accepts; want 6, 0",
                     out_q.size(), extra);
        end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++;
            if (out_q[i].d !== in_q[i] || out_q[i].l !== is_last(i)) begin
                fails++;
                $display("FAIL burst_beat%0d: got d=%h l=%b want d=%h l=%b",
                         i, out_q[i].d, out_q[i].l, in_q[i], is_last(i));
            end
        end
        checks++;
        if (sts_pkt_cntr !== 32'd2) begin
            fails++;
            $display("FAIL burst_pkt_cntr: got %0d want 2", sts_pkt_cntr);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int cycles;
        do_reset(5, 1'b0, 0);
        sink_rand = 1;
        exp_len = '{5};
        send(30, 70, sent, cycles);
        drain(30, 1000);
        sink_rand = 0;
        checks++;
        if (out_q.size() !== 30 || sent !== 30) begin
            fails++;
            $display("FAIL bp_count: got %0d in, %0d out; want 30, 30", sent, out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++;
            if (out_q[i].d !== in_q[i] || out_q[i].l !== is_last(i)) begin
                fails++;
                $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b",
                         i, out_q[i].d, out_q[i].l, in_q[i], is_last(i));
            end
        end
        checks++;
        if (stall_viol !== 0) begin
            fails++;
            $display("FAIL bp_stable: %0d changes while stalled, want 0", stall_viol);
        end
        checks++;
        if (sts_pkt_cntr !== 32'd6) begin
            fails++;
            $display("FAIL bp_pkt_cntr: got %0d want 6", sts_pkt_cntr);
        end
    endtask

    task automatic test_len_change();
        int sent;
        int cycles;
        do_reset(4, 1'b0, 0);
        sink_on = 1;
        exp_len = '{4, 2};
        send(2, 100, sent, cycles);
        cfg_length = 32'd2;
        send(8, 80, sent, cycles);
        drain(10, 100);
        checks++;
        if (out_q.size() !== 10) begin
            fails++;
            $display("FAIL lenchg_count: got %0d beats want 10", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++;
            if (out_q[i].d !== in_q[i] || out_q[i].l !== is_last(i)) begin
                fails++;
                $display("FAIL lenchg_beat%0d: got d=%h l=%b want d=%h l=%b",
                         i, out_q[i].d, out_q[i].l, in_q[i], is_last(i));
            end
        end
        checks++;
        if (sts_pkt_cntr !== 32'd4) begin
            fails++;
            $display("FAIL lenchg_pkt_cntr: got %0d want 4", sts_pkt_cntr);
        end
    endtask

    task automatic test_single_beat();
        int sent;
        int cycles;
        int acc;
        do_reset(1, 1'b0, 0);
        sink_on = 1;
        exp_len = '{1};
        send(5, 100, sent, cycles);
        drain(5, 50);
        checks++;
        if (out_q.size() !== 5 || sts_pkt_cntr !== 32'd5) begin
            fails++;
            $display("FAIL single_count: got %0d beats, cntr %0d; want 5, 5",
                     out_q.size(), sts_pkt_cntr);
        end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++;
            if (out_q[i].d !== in_q[i] || out_q[i].l !== 1'b1) begin
                fails++;
                $display("FAIL single_beat%0d: got d=%h l=%b want d=%h l=1",
                         i, out_q[i].d, out_q[i].l, in_q[i]);
            end
        end
        do_reset(0, 1'b0, 0);
        acc = 0;
        src_if.vld = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            if (src_if.rdy !== 1'b0 || sts_busy !== 1'b0) acc++;
        end
        src_if.vld = 1'b0;
        checks++;
        if (acc !== 0) begin
            fails++;
            $display("FAIL zero_len_ready: tready/busy high on %0d cycles, want 0", acc);
        end
    endtask

    task automatic test_reset_mid();
        int sent;
        int cycles;
        do_reset(8, 1'b0, 0);
        sink_on = 1;
        exp_len = '{8};
        send(3, 100, sent, cycles);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        checks++;
        if ({src_if.rdy, snk_if.vld, m_last, sts_busy} !== 4'b0000 || sts_pkt_cntr !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got flags=%b cntr=%0d want 0000 0",
                     {src_if.rdy, snk_if.vld, m_last, sts_busy}, sts_pkt_cntr);
        end
        in_q.delete();
        out_q.delete();
        out_cyc.delete();
        send(8, 100, sent, cycles);
        drain(8, 100);
        checks++;
        if (out_q.size() !== 8) begin
            fails++;
            $display("FAIL rstmid_count: got %0d beats want 8", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            checks++;
            if (out_q[i].d !== in_q[i] || out_q[i].l !== is_last(i)) begin
                fails++;
                $display("FAIL rstmid_beat%0d: got d=%h l=%b want d=%h l=%b",
                         i, out_q[i].d, out_q[i].l, in_q[i], is_last(i));
            end
        end
        checks++;
        if (sts_pkt_cntr !== 32'd1) begin
            fails++;
            $display("FAIL rstmid_pkt_cntr: got %0d want 1", sts_pkt_cntr);
        end
    endtask

    initial begin
        aresetn    = 1'b0;
        cfg_length = '0;
        cfg_mode   = 1'b0;
        cfg_pkts   = '0;
        cfg_trig   = 1'b0;
        src_if.vld = 1'b0;
        src_if.dat = '0;
        test_reset();
        test_continuous();
        test_burst();
        test_backpressure();
        test_len_change();
        test_single_beat();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axis_frame_packetizer.md
AXIS_FRAME_PACKETIZER -- requirements
Module: axis_frame_packetizer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning data width in bits of both AXI-Stream ports.
REQ-002 SHALL have parameter CNTR_WIDTH, default 32, meaning the width of the length, packet-budget and status counters.
REQ-003 SHALL have port aclk, input, 1, the single clock.
REQ-004 SHALL have port aresetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port cfg_length, input, CNTR_WIDTH, beats per packet; 0 means disabled.
REQ-006 SHALL have port cfg_mode, input, 1, packet mode: 0 = continuous, 1 = burst.
REQ-007 SHALL have port cfg_pkts, input, CNTR_WIDTH, packets per burst.
REQ-008 SHALL have port cfg_trig, input, 1, single-cycle burst start pulse.
REQ-009 SHALL have ports s_axis_tready (output, 1), s_axis_tdata (input, AXIS_TDATA_WIDTH) and s_axis_tvalid (input, 1), forming the slave stream.
REQ-010 SHALL have ports m_axis_tready (input, 1), m_axis_tdata (output, AXIS_TDATA_WIDTH), m_axis_tvalid (output, 1) and m_axis_tlast (output, 1), forming the master stream.
REQ-011 SHALL have port sts_busy, output, 1, high while in RUN.
REQ-012 SHALL have port sts_pkt_cntr, output, CNTR_WIDTH, count of completed packets; wraps modulo 2^CNTR_WIDTH.

Function
REQ-013 SHALL implement two states, IDLE and RUN.
- IDLE: s_axis_tready=0.
- RUN: s_axis_tready=1 when the output buffer has space.
REQ-014 SHALL move IDLE->RUN in continuous mode when cfg_mode=0 and cfg_length!=0, latching cfg_length into len_reg and clearing beat_cnt.
REQ-015 SHALL move IDLE->RUN in burst mode when cfg_mode=1, cfg_trig=1, cfg_length!=0 and cfg_pkts!=0, latching len_reg and setting pkt_left=cfg_pkts.
REQ-016 SHALL ignore cfg_trig in RUN, in continuous mode, or when cfg_length=0 or cfg_pkts=0.
REQ-017 SHALL increment beat_cnt on each accepted input beat (s_axis_tvalid & s_axis_tready); the beat with beat_cnt==len_reg-1 is the last beat, tagged tlast=1.
REQ-018 SHALL, on an accepted last beat:
- clear beat_cnt;
- increment sts_pkt_cntr;
- decrement pkt_left in burst mode.
REQ-019 SHALL, on an accepted last beat, re-latch cfg_length and stay in RUN if (cfg_mode=0 and cfg_length!=0) or (cfg_mode=1 and pkt_left>1); otherwise go to IDLE.
REQ-020 SHALL sample cfg_length and cfg_mode only at packet boundaries; changes mid-packet SHALL NOT alter the current packet.
REQ-021 SHALL, with len_reg=1, emit every beat with tlast=1.
REQ-022 SHALL pass input beats through a 2-entry skid buffer carrying tdata and tlast.
- Output is registered; latency from input accept to m_axis_tvalid is 1 cycle.
- Throughput is 1 beat/cycle under continuous m_axis_tready.
- s_axis_tready SHALL NOT depend combinationally on m_axis_tready.
REQ-023 SHALL keep m_axis_tdata and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 SHALL continue draining buffered beats after entering IDLE, so no accepted beat is ever lost.
REQ-025 SHALL NOT drop or duplicate input data; the block throttles the source and never discards beats.

Reset
REQ-026 SHALL, while aresetn=0 at a rising aclk edge, set:
- state to IDLE;
- beat_cnt, len_reg, pkt_left and sts_pkt_cntr to 0;
- skid buffer to empty;
- m_axis_tvalid, m_axis_tlast, s_axis_tready and sts_busy to 0.
REQ-027 SHALL, on reset mid-packet, discard the partial packet and buffered beats, with no tlast emitted for it.

Structure
REQ-028 SHALL place state encoding (IDLE, RUN) and the mode constants (CONT=0, BURST=1) in a shared package, axis_pkt_pkg.
REQ-029 SHALL implement the skid buffer as one sub-module, axis_skid_buffer, parametrised on data width plus 1 bit for tlast.

Verification
REQ-030 SHALL verify continuous mode: cfg_length=4, cfg_mode=0, source and sink always ready, 12 beats -> 3 packets with tlast on beats 4, 8 and 12, sts_pkt_cntr=3, 1 beat/cycle.
REQ-031 SHALL verify burst mode: cfg_mode=1, cfg_pkts=2, cfg_length=3, one cfg_trig -> exactly 6 beats out, then IDLE and s_axis_tready=0; a second trig mid-burst has no effect.
REQ-032 SHALL verify backpressure: random m_axis_tready (50%), cfg_length=5 -> output data sequence equals input sequence, tlast every 5th beat, tdata stable while stalled.
REQ-033 SHALL verify a length change mid-packet: cfg_length 4->2 after beat 2 -> current packet 4 beats, following packets 2 beats.
REQ-034 SHALL verify the single-beat edge: cfg_length=1 -> tlast=1 on every beat; cfg_length=0 -> s_axis_tready stays 0.
REQ-035 SHALL verify reset mid-operation: aresetn low for 1 cycle after beat 3 of 8 -> all outputs 0, sts_pkt_cntr=0, next packet starts at beat_cnt=0.
